tff_toggle_monitor: RTL and testbench

- Downstream stage for the toggle flip-flop. Consumes its q output and checks it against the expected toggle behaviour.
- Per-cycle outputs: registered rise and fall strobes.
- On command, runs a measurement window that reports the toggle count, the edge-to-edge period and a stuck-output alarm.
- Used in system self-check and bring-up of TFF-based dividers and counters.

---
 rtl/tff_toggle_monitor_if.sv | 27 ++
 rtl/tff_toggle_monitor.sv | 132 +++++++++++++
 tb/tb_tff_toggle_monitor.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tff_toggle_monitor_if.sv
// Signal bundle between a TFF under test and its toggle monitor.
// The master side drives the TFF output and the window commands,
// the slave side (the monitor) returns strobes and window results.
interface tff_toggle_monitor_if #(
  parameter int CNT_W = 8
);
  logic             q_in;
  logic             start;
  logic             stop;
  logic             rise;
  logic             fall;
  logic             busy;
  logic             done;
  logic             stuck;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] period;

  modport master (
    output q_in, start, stop,
    input  rise, fall, busy, done, stuck, toggle_cnt, period
  );

  modport slave (
    input  q_in, start, stop,
    output rise, fall, busy, done, stuck, toggle_cnt, period
  );
endinterface

// File: rtl/tff_toggle_monitor.sv
// Toggle monitor for a TFF output: per-cycle rise/fall strobes plus a
// start/stop measurement window reporting edge count, edge-to-edge
// period and a stuck-output alarm.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | results held, waiting for start
// WAIT_EDGE | window open, no edge seen yet
// MEASURE   | window open, counting edges and measuring period
// DONE      | one-cycle done pulse, then back to IDLE
module tff_toggle_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  tff_toggle_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic             q_d;
  logic             rise_q;
  logic             fall_q;
  logic             edge_det;
  logic             stuck_q;
  logic             stuck_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_nxt;
  logic [CNT_W-1:0] gap_inc;

  assign edge_det = mon.q_in ^ q_d;
  assign gap_inc  = (gap_q == CNT_MAX) ? gap_q : gap_q + 1'b1;

  // Edge strobes, independent of the window FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_d    <= mon.q_in;
      rise_q <= mon.q_in & ~q_d;
      fall_q <= ~mon.q_in & q_d;
    end
  end

  // Window state and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      gap_q    <= '0;
      stuck_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_q    <= cnt_nxt;
      period_q <= period_nxt;
      gap_q    <= gap_nxt;
      stuck_q  <= stuck_nxt;
    end
  end

  // Next-state and result update; an edge always beats a timeout.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_q;
    period_nxt = period_q;
    gap_nxt    = gap_q;
    stuck_nxt  = stuck_q;
    case (state)
      IDLE: begin
        if (mon.start) begin
          cnt_nxt    = '0;
          period_nxt = '0;
          gap_nxt    = '0;
          stuck_nxt  = 1'b0;
          state_nxt  = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        if (edge_det) begin
          cnt_nxt   = CNT_W'(1);
          gap_nxt   = '0;
          state_nxt = MEASURE;
        end else if (gap_q == GAP_LAST) begin
          stuck_nxt = 1'b1;
          state_nxt = DONE;
        end else if (mon.stop) begin
          state_nxt = DONE;
        end else begin
          gap_nxt = gap_inc;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          period_nxt = gap_q + 1'b1;
          cnt_nxt    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          gap_nxt    = '0;
          if (mon.stop) state_nxt = DONE;
        end else if (gap_q == GAP_LAST) begin
          stuck_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          gap_nxt = gap_inc;
          if (mon.stop) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mon.rise       = rise_q;
  assign mon.fall       = fall_q;
  assign mon.busy       = (state == WAIT_EDGE) || (state == MEASURE);
  assign mon.done       = (state == DONE);
  assign mon.stuck      = stuck_q;
  assign mon.toggle_cnt = cnt_q;
  assign mon.period     = period_q;

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// Bench for tff_toggle_monitor: two instances (8-bit/TIMEOUT 16 and
// 4-bit/TIMEOUT 6) share one stimulus stream. A timestamp-based model
// of the window rules tracks both and is checked in the random phase;
// directed scenarios check fixed values.
module tb_tff_toggle_monitor;

  localparam int T8 = 16;
  localparam int T4 = 6;

  typedef struct {
    bit qp;
    bit in_win;
    bit have_edge;
    bit rise;
    bit fall;
    bit done;
    bit stuck;
    int cnt;
    int period;
    int ref_cyc;
  } mdl_t;

  logic clk;
  logic rst;
  logic q;
  logic st;
  logic sp;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  mdl_t m8;
  mdl_t m4;

  tff_toggle_monitor_if #(.CNT_W(8)) if8 ();
  tff_toggle_monitor_if #(.CNT_W(4)) if4 ();

  assign if8.q_in  = q;
  assign if8.start = st;
  assign if8.stop  = sp;
  assign if4.q_in  = q;
  assign if4.start = st;
  assign if4.stop  = sp;

  tff_toggle_monitor #(.CNT_W(8), .TIMEOUT(T8)) dut8 (
    .clk (clk),
    .rst (rst),
    .mon (if8)
  );

  tff_toggle_monitor #(.CNT_W(4), .TIMEOUT(T4)) dut4 (
    .clk (clk),
    .rst (rst),
    .mon (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window rules expressed with cycle timestamps: period is the distance
  // between edge timestamps, timeout is tmo cycles since the reference
  // point (window start or last edge) with no edge on that cycle.
  function automatic mdl_t mstep(mdl_t m, int c, bit r, bit qi, bit s, bit p,
                                 int cmax, int tmo);
    mdl_t n;
    bit   e;
    n = m;
    if (!r) begin
      n = '{default: 0};
      return n;
    end
    e      = (qi != m.qp);
    n.rise = qi & ~m.qp;
    n.fall = ~qi & m.qp;
    n.qp   = qi;
    n.done = 1'b0;
    if (m.done) begin
      // closing cycle: nothing accepted
    end else if (!m.in_win) begin
      if (s) begin
        n.in_win    = 1'b1;
        n.have_edge = 1'b0;
        n.cnt       = 0;
        n.period    = 0;
        n.stuck     = 1'b0;
        n.ref_cyc   = c;
      end
    end else if (e) begin
      if (m.have_edge) n.period = c - m.ref_cyc;
      n.cnt       = (m.cnt < cmax) ? m.cnt + 1 : cmax;
      n.have_edge = 1'b1;
      n.ref_cyc   = c;
      if (p && m.have_edge) begin
        n.in_win = 1'b0;
        n.done   = 1'b1;
      end
    end else if (c - m.ref_cyc >= tmo) begin
      n.stuck  = 1'b1;
      n.in_win = 1'b0;
      n.done   = 1'b1;
    end else if (p) begin
      n.in_win = 1'b0;
      n.done   = 1'b1;
    end
    return n;
  endfunction

  // Advance one clock with the current inputs; outputs are read 1ns later.
  task automatic cycle();
    m8 = mstep(m8, cyc, rst, q, st, sp, 255, T8);
    m4 = mstep(m4, cyc, rst, q, st, sp, 15, T4);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    st = 1'b1;
    cycle();
    st = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    q   = 1'b1;
    st  = 1'b0;
    sp  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if ({if8.rise, if8.fall, if8.busy, if8.done, if8.stuck, if8.toggle_cnt, if8.period} !== 21'd0) begin
        n_bad++;
        $display("FAIL reset_outputs8: got %b want all zero",
                 {if8.rise, if8.fall, if8.busy, if8.done, if8.stuck, if8.toggle_cnt, if8.period});
      end
      n_cmp++;
      if ({if4.rise, if4.fall, if4.busy, if4.done, if4.stuck, if4.toggle_cnt, if4.period} !== 13'd0) begin
        n_bad++;
        $display("FAIL reset_outputs4: got %b want all zero",
                 {if4.rise, if4.fall, if4.busy, if4.done, if4.stuck, if4.toggle_cnt, if4.period});
      end
    end
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (if8.rise !== 1'b1 || if8.fall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_rise: got rise=%b fall=%b want rise=1 fall=0", if8.rise, if8.fall);
    end
    n_cmp++;
    if (if8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy: got %b want 0", if8.busy);
    end
    cycle();
    n_cmp++;
    if (if8.rise !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rise_once: got %b want 0", if8.rise);
    end
  endtask

  task automatic test_fast_toggle();
    cycle();
    pulse_start();
    n_cmp++;
    if (if8.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fast_busy_after_start: got %b want 1", if8.busy);
    end
    for (int i = 0; i < 10; i++) begin
      q = ~q;
      cycle();
    end
    n_cmp++;
    if (if8.busy !== 1'b1 || if8.done !== 1'b0 || if8.toggle_cnt !== 8'd10) begin
      n_bad++;
      $display("FAIL fast_pre_stop: got busy=%b done=%b cnt=%0d want 1 0 10",
               if8.busy, if8.done, if8.toggle_cnt);
    end
    sp = 1'b1;
    cycle();
    sp = 1'b0;
    n_cmp++;
    if (if8.done !== 1'b1 || if8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fast_done_busy: got done=%b busy=%b want 1 0", if8.done, if8.busy);
    end
    n_cmp++;
    if (if8.toggle_cnt !== 8'd10 || if8.period !== 8'd1 || if8.stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL fast_results8: got cnt=%0d period=%0d stuck=%b want 10 1 0",
               if8.toggle_cnt, if8.period, if8.stuck);
    end
    n_cmp++;
    if (if4.toggle_cnt !== 4'd10 || if4.period !== 4'd1 || if4.done !== 1'b1) begin
      n_bad++;
      $display("FAIL fast_results4: got cnt=%0d period=%0d done=%b want 10 1 1",
               if4.toggle_cnt, if4.period, if4.done);
    end
    cycle();
    n_cmp++;
    if (if8.done !== 1'b0 || if8.toggle_cnt !== 8'd10) begin
      n_bad++;
      $display("FAIL fast_done_single: got done=%b cnt=%0d want 0 10", if8.done, if8.toggle_cnt);
    end
  endtask

  task automatic test_slow_toggle();
    cycle();
    pulse_start();
    for (int e = 0; e < 4; e++) begin
      q = ~q;
      cycle();
      n_cmp++;
      if (if8.rise !== q || if8.fall !== ~q) begin
        n_bad++;
        $display("FAIL slow_strobe_%0d: got rise=%b fall=%b want %b %b", e, if8.rise, if8.fall, q, ~q);
      end
      cycle();
      cycle();
      n_cmp++;
      if (if8.rise !== 1'b0 || if8.fall !== 1'b0) begin
        n_bad++;
        $display("FAIL slow_quiet_%0d: got rise=%b fall=%b want 0 0", e, if8.rise, if8.fall);
      end
    end
    sp = 1'b1;
    cycle();
    sp = 1'b0;
    n_cmp++;
    if (if8.done !== 1'b1 || if8.toggle_cnt !== 8'd4 || if8.period !== 8'd3 || if8.stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL slow_results8: got done=%b cnt=%0d period=%0d stuck=%b want 1 4 3 0",
               if8.done, if8.toggle_cnt, if8.period, if8.stuck);
    end
    n_cmp++;
    if (if4.toggle_cnt !== 4'd4 || if4.period !== 4'd3 || if4.stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL slow_results4: got cnt=%0d period=%0d stuck=%b want 4 3 0",
               if4.toggle_cnt, if4.period, if4.stuck);
    end
    cycle();
  endtask

  task automatic test_timeout();
    bit seen8;
    bit seen4;
    cycle();
    pulse_start();
    for (int k = 1; k <= T8; k++) begin
      cycle();
      n_cmp++;
      if (if8.done !== (k == T8)) begin
        n_bad++;
        $display("FAIL timeout_done8_k%0d: got %b want %b", k, if8.done, (k == T8));
      end
      n_cmp++;
      if (if4.done !== (k == T4)) begin
        n_bad++;
        $display("FAIL timeout_done4_k%0d: got %b want %b", k, if4.done, (k == T4));
      end
    end
    n_cmp++;
    if (if8.stuck !== 1'b1 || if8.toggle_cnt !== 8'd0 || if8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_results8: got stuck=%b cnt=%0d busy=%b want 1 0 0",
               if8.stuck, if8.toggle_cnt, if8.busy);
    end
    n_cmp++;
    if (if4.stuck !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_stuck4: got %b want 1", if4.stuck);
    end
    cycle();
    pulse_start();
    n_cmp++;
    if (if8.stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_stuck_cleared: got %b want 0", if8.stuck);
    end
    q = ~q;
    cycle();
    cycle();
    q = ~q;
    cycle();
    seen8 = 1'b0;
    seen4 = 1'b0;
    for (int k = 1; k <= 40 && !seen8; k++) begin
      cycle();
      if (if4.done === 1'b1 && !seen4) begin
        seen4 = 1'b1;
        n_cmp++;
        if (k != T4 || if4.stuck !== 1'b1 || if4.toggle_cnt !== 4'd2 || if4.period !== 4'd2) begin
          n_bad++;
          $display("FAIL frozen_results4: got k=%0d stuck=%b cnt=%0d period=%0d want %0d 1 2 2",
                   k, if4.stuck, if4.toggle_cnt, if4.period, T4);
        end
      end
      if (if8.done === 1'b1) begin
        seen8 = 1'b1;
        n_cmp++;
        if (k != T8 || if8.stuck !== 1'b1 || if8.toggle_cnt !== 8'd2 || if8.period !== 8'd2) begin
          n_bad++;
          $display("FAIL frozen_results8: got k=%0d stuck=%b cnt=%0d period=%0d want %0d 1 2 2",
                   k, if8.stuck, if8.toggle_cnt, if8.period, T8);
        end
      end
    end
    n_cmp++;
    if (!seen8 || !seen4) begin
      n_bad++;
      $display("FAIL frozen_no_done: got seen8=%b seen4=%b want 1 1", seen8, seen4);
    end
    cycle();
  endtask

  task automatic test_saturate();
    cycle();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      q = ~q;
      if (i == 10) st = 1'b1;
      cycle();
      st = 1'b0;
      if (i == 10) begin
        n_cmp++;
        if (if8.toggle_cnt !== 8'd11 || if8.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL sat_restart_ignored: got cnt=%0d busy=%b want 11 1", if8.toggle_cnt, if8.busy);
        end
      end
    end
    n_cmp++;
    if (if4.toggle_cnt !== 4'd15 || if4.period !== 4'd1) begin
      n_bad++;
      $display("FAIL sat_cnt4: got cnt=%0d period=%0d want 15 1", if4.toggle_cnt, if4.period);
    end
    n_cmp++;
    if (if8.toggle_cnt !== 8'd20) begin
      n_bad++;
      $display("FAIL sat_cnt8: got %0d want 20", if8.toggle_cnt);
    end
    sp = 1'b1;
    cycle();
    sp = 1'b0;
    n_cmp++;
    if (if4.done !== 1'b1 || if4.toggle_cnt !== 4'd15 || if4.stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_done4: got done=%b cnt=%0d stuck=%b want 1 15 0",
               if4.done, if4.toggle_cnt, if4.stuck);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    bit any_done;
    cycle();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      q = ~q;
      cycle();
    end
    n_cmp++;
    if (if8.toggle_cnt !== 8'd5) begin
      n_bad++;
      $display("FAIL rstmid_pre_cnt: got %0d want 5", if8.toggle_cnt);
    end
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    n_cmp++;
    if (if8.toggle_cnt !== 8'd0 || if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.period !== 8'd0) begin
      n_bad++;
      $display("FAIL rstmid_cleared: got cnt=%0d busy=%b done=%b period=%0d want 0 0 0 0",
               if8.toggle_cnt, if8.busy, if8.done, if8.period);
    end
    any_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      any_done |= if8.done;
    end
    n_cmp++;
    if (any_done !== 1'b0 || if8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_no_done: got done_seen=%b busy=%b want 0 0", any_done, if8.busy);
    end
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      q = ~q;
      cycle();
    end
    sp = 1'b1;
    cycle();
    sp = 1'b0;
    n_cmp++;
    if (if8.done !== 1'b1 || if8.toggle_cnt !== 8'd10 || if8.period !== 8'd1 || if8.stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_rerun: got done=%b cnt=%0d period=%0d stuck=%b want 1 10 1 0",
               if8.done, if8.toggle_cnt, if8.period, if8.stuck);
    end
    cycle();
  endtask

  task automatic test_simultaneous();
    cycle();
    st = 1'b1;
    sp = 1'b1;
    cycle();
    st = 1'b0;
    sp = 1'b0;
    n_cmp++;
    if (if8.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sim_start_wins: got busy=%b want 1", if8.busy);
    end
    sp = 1'b1;
    cycle();
    sp = 1'b0;
    n_cmp++;
    if (if8.done !== 1'b1 || if8.stuck !== 1'b0 || if8.toggle_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL sim_stop_no_edge: got done=%b stuck=%b cnt=%0d want 1 0 0",
               if8.done, if8.stuck, if8.toggle_cnt);
    end
    cycle();
    pulse_start();
    for (int k = 1; k < T8; k++) cycle();
    sp = 1'b1;
    cycle();
    sp = 1'b0;
    n_cmp++;
    if (if8.done !== 1'b1 || if8.stuck !== 1'b1) begin
      n_bad++;
      $display("FAIL sim_timeout_and_stop: got done=%b stuck=%b want 1 1", if8.done, if8.stuck);
    end
    st = 1'b1;
    cycle();
    st = 1'b0;
    n_cmp++;
    if (if8.busy !== 1'b0 || if8.stuck !== 1'b1) begin
      n_bad++;
      $display("FAIL sim_start_in_done: got busy=%b stuck=%b want 0 1", if8.busy, if8.stuck);
    end
    pulse_start();
    for (int k = 1; k < T8; k++) cycle();
    q = ~q;
    cycle();
    n_cmp++;
    if (if8.busy !== 1'b1 || if8.stuck !== 1'b0 || if8.done !== 1'b0 || if8.toggle_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL sim_edge_beats_timeout: got busy=%b stuck=%b done=%b cnt=%0d want 1 0 0 1",
               if8.busy, if8.stuck, if8.done, if8.toggle_cnt);
    end
    sp = 1'b1;
    cycle();
    sp = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    int mode;
    logic [20:0] exp8;
    logic [20:0] act8;
    logic [12:0] exp4;
    logic [12:0] act4;
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) mode = $urandom_range(0, 3);
      rst = ($urandom_range(0, 299) != 0);
      st  = ($urandom_range(0, 9) == 0);
      sp  = ($urandom_range(0, 19) == 0);
      case (mode)
        0: q = q;
        1: if ($urandom_range(0, 7) == 0) q = ~q;
        2: if ($urandom_range(0, 1) == 0) q = ~q;
        default: q = ~q;
      endcase
      cycle();
      exp8 = {m8.rise, m8.fall, m8.in_win, m8.done, m8.stuck, 8'(m8.cnt), 8'(m8.period)};
      act8 = {if8.rise, if8.fall, if8.busy, if8.done, if8.stuck, if8.toggle_cnt, if8.period};
      exp4 = {m4.rise, m4.fall, m4.in_win, m4.done, m4.stuck, 4'(m4.cnt), 4'(m4.period)};
      act4 = {if4.rise, if4.fall, if4.busy, if4.done, if4.stuck, if4.toggle_cnt, if4.period};
      n_cmp++;
      if (act8 !== exp8) begin
        n_bad++;
        $display("FAIL random8_c%0d: got %h want %h (rise,fall,busy,done,stuck,cnt,period)", i, act8, exp8);
      end
      n_cmp++;
      if (act4 !== exp4) begin
        n_bad++;
        $display("FAIL random4_c%0d: got %h want %h (rise,fall,busy,done,stuck,cnt,period)", i, act4, exp4);
      end
    end
    rst = 1'b1;
    st  = 1'b0;
    sp  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    m8    = '{default: 0};
    m4    = '{default: 0};
    rst   = 1'b0;
    q     = 1'b0;
    st    = 1'b0;
    sp    = 1'b0;
    test_reset();
    test_fast_toggle();
    test_slow_toggle();
    test_timeout();
    test_saturate();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
